// File: rtl/sdp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdp_pkg
// Purpose  : Shared types and constants for the serial debug port slave.
//            Holds the controller state encoding, the frame bit constants,
//            the command encodings and the frame parity helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sdp_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CMD     = 4'd1,
        ST_ADDR    = 4'd2,
        ST_STRB    = 4'd3,
        ST_DATA    = 4'd4,
        ST_PAR     = 4'd5,
        ST_STOP    = 4'd6,
        ST_TURN    = 4'd7,
        ST_BUS_REQ = 4'd8,
        ST_BUS_RSP = 4'd9,
        ST_RESP    = 4'd10,
        ST_TAIL    = 4'd11
    } sdp_state_t;

    localparam logic CMD_WR    = 1'b1;
    localparam logic CMD_RD    = 1'b0;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic ACK_OK    = 1'b0;

    // Parity operand container; narrower fields are zero-extended, which
    // leaves their XOR unchanged.
    localparam int SDP_VEC_W = 128;
    typedef logic [SDP_VEC_W-1:0] sdp_vec_t;

    // XOR of every bit in vec, seeded with cnt_init.
    function automatic logic sdp_parity(input logic cnt_init, input sdp_vec_t vec);
        return cnt_init ^ (^vec);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdp_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sdp_sync_edge
// Purpose  : Two-flop synchroniser for an asynchronous pad input, followed by
//            a history flop that yields single-cycle rise/fall pulses.
// Ports    : clk   - system clock
//            rst_n - synchronous active-low reset
//            din   - asynchronous input
//            dout  - synchronised level
//            rise  - one-cycle pulse on a synchronised 0->1 transition
//            fall  - one-cycle pulse on a synchronised 1->0 transition
// Revision : 1.0 - initial release
// ============================================================================
module sdp_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Reset all stages to the same level so that no edge is reported
    // when reset is released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign dout = sync;
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule
`default_nettype wire

// File: rtl/sdp_slave.sv
`default_nettype none
// ============================================================================
// Module   : sdp_slave
// Purpose  : Target-side serial debug port endpoint. Decodes host read/write
//            frames, performs one bus access per frame and shifts the
//            acknowledge/status/read data back to the host.
// Ports    : clk, rst_n              - system clock, sync active-low reset
//            sdp_ck, sdp_di          - host serial clock / data (async)
//            sdp_do, sdp_oe          - slave serial data / pad drive enable
//            bus_req_*               - debug bus request (valid/ready)
//            bus_rsp_*               - debug bus response (single cycle)
// Revision : 1.0 - initial release
// ============================================================================
module sdp_slave
    import sdp_pkg::*;
#(
    parameter int N_AW   = 32,
    parameter int N_DW   = 32,
    parameter int N_DM   = 4,
    parameter int BUS_TO = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sdp_ck,
    input  logic            sdp_di,
    output logic            sdp_do,
    output logic            sdp_oe,
    output logic            bus_req_vld,
    input  logic            bus_req_rdy,
    output logic            bus_req_we,
    output logic [N_AW-1:0] bus_req_addr,
    output logic [N_DW-1:0] bus_req_wdata,
    output logic [N_DM-1:0] bus_req_wstrb,
    input  logic            bus_rsp_vld,
    input  logic [N_DW-1:0] bus_rsp_rdata,
    input  logic            bus_rsp_err
);

    localparam int RW      = N_DW + 3;                      // start, ack, data, parity
    localparam int TO_LAST = (BUS_TO > 0) ? BUS_TO - 1 : 0;

    sdp_state_t      state, state_nx;
    logic            sck_fall, sck_rise, di_s;
    logic            sck_lvl_unused, di_rise_unused, di_fall_unused;
    logic            cmd, par_bit, frame_err, err, par_ok, timeout;
    logic [5:0]      cnt, resp_cnt;
    logic [1:0]      turn_cnt;
    logic [31:0]     to_cnt;
    logic [N_AW-1:0] addr;
    logic [N_DM-1:0] wstrb;
    logic [N_DW-1:0] wdata, rdata;
    logic [RW-1:0]   shreg;
    logic            oe_q, do_q;

    // sck idles low after reset; di idles high so IDLE never sees a start bit.
    sdp_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .din(sdp_ck),
        .dout(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
    );

    sdp_sync_edge #(.RST_VAL(1'b1)) u_sync_di (
        .clk(clk), .rst_n(rst_n), .din(sdp_di),
        .dout(di_s), .rise(di_rise_unused), .fall(di_fall_unused)
    );

    always_comb begin
        if (cmd == CMD_WR)
            par_ok = (par_bit == sdp_parity(1'b1, sdp_vec_t'({addr, wdata})));
        else
            par_ok = (par_bit == sdp_parity(1'b0, sdp_vec_t'(addr)));
    end

    assign timeout = (BUS_TO != 0) && (to_cnt == 32'(TO_LAST));

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (sck_fall && di_s == START_BIT) state_nx = ST_CMD;
            ST_CMD:     if (sck_fall) state_nx = ST_ADDR;
            ST_ADDR:    if (sck_fall && cnt == 6'd0)
                            state_nx = (cmd == CMD_WR) ? ST_STRB : ST_PAR;
            ST_STRB:    if (sck_fall && cnt == 6'd0) state_nx = ST_DATA;
            ST_DATA:    if (sck_fall && cnt == 6'd0) state_nx = ST_PAR;
            ST_PAR:     if (sck_fall) state_nx = ST_STOP;
            // A framing error parks here until the line returns high.
            ST_STOP:    if (sck_fall && di_s == STOP_BIT) begin
                            if (frame_err)   state_nx = ST_IDLE;
                            else if (par_ok) state_nx = ST_BUS_REQ;
                            else             state_nx = ST_TURN;
                        end
            ST_BUS_REQ: if (bus_req_rdy) state_nx = ST_BUS_RSP;
            ST_BUS_RSP: if (bus_rsp_vld || timeout) state_nx = ST_TURN;
            ST_TURN:    if (sck_rise && turn_cnt == 2'd2) state_nx = ST_RESP;
            ST_RESP:    if (sck_rise && resp_cnt == 6'd0) state_nx = ST_TAIL;
            ST_TAIL:    if (sck_rise) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        bus_req_vld   = (state == ST_BUS_REQ);
        bus_req_we    = bus_req_vld & (cmd == CMD_WR);
        bus_req_addr  = bus_req_vld ? addr  : '0;
        bus_req_wdata = bus_req_we  ? wdata : '0;
        bus_req_wstrb = bus_req_we  ? wstrb : '0;
        sdp_oe        = oe_q;
        sdp_do        = do_q;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd       <= CMD_RD;
            cnt       <= '0;
            addr      <= '0;
            wstrb     <= '0;
            wdata     <= '0;
            rdata     <= '0;
            par_bit   <= 1'b0;
            frame_err <= 1'b0;
            err       <= 1'b0;
            to_cnt    <= '0;
            turn_cnt  <= '0;
            resp_cnt  <= '0;
            shreg     <= '0;
            oe_q      <= 1'b0;
            do_q      <= 1'b1;
        end else begin
            case (state)
                ST_CMD: if (sck_fall) begin
                    cmd       <= di_s;
                    cnt       <= 6'(N_AW - 1);
                    addr      <= '0;
                    wstrb     <= '0;
                    wdata     <= '0;
                    frame_err <= 1'b0;
                end
                ST_ADDR: if (sck_fall) begin
                    addr <= {addr[N_AW-2:0], di_s};
                    cnt  <= (cnt == 6'd0) ? 6'(N_DM - 1) : cnt - 6'd1;
                end
                ST_STRB: if (sck_fall) begin
                    wstrb <= {wstrb[N_DM-2:0], di_s};
                    cnt   <= (cnt == 6'd0) ? 6'(N_DW - 1) : cnt - 6'd1;
                end
                ST_DATA: if (sck_fall) begin
                    wdata <= {wdata[N_DW-2:0], di_s};
                    cnt   <= cnt - 6'd1;
                end
                ST_PAR: if (sck_fall) par_bit <= di_s;
                ST_STOP: if (sck_fall) begin
                    if (di_s != STOP_BIT) begin
                        frame_err <= 1'b1;
                    end else if (!frame_err) begin
                        err      <= ~par_ok;
                        rdata    <= '0;
                        turn_cnt <= '0;
                    end
                end
                ST_BUS_REQ: if (bus_req_rdy) to_cnt <= '0;
                ST_BUS_RSP: begin
                    if (bus_rsp_vld) begin
                        err   <= bus_rsp_err;
                        rdata <= bus_rsp_err ? '0 : bus_rsp_rdata;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                        if (timeout) err <= 1'b1;
                    end
                end
                ST_RESP: if (sck_rise) begin
                    if (resp_cnt == 6'd0) begin
                        do_q <= 1'b1;
                    end else begin
                        do_q     <= shreg[RW-2];
                        shreg    <= {shreg[RW-2:0], 1'b0};
                        resp_cnt <= resp_cnt - 6'd1;
                    end
                end
                ST_TAIL: if (sck_rise) begin
                    oe_q <= 1'b0;
                    do_q <= 1'b1;
                end
                default: ;
            endcase

            // Turnaround runs alongside the bus access: the first two rises
            // after the stop bit take the pad and drive idle-high; the first
            // rise once both are finished launches the response start bit.
            if (sck_rise && (state inside {ST_BUS_REQ, ST_BUS_RSP, ST_TURN})) begin
                oe_q <= 1'b1;
                if (state == ST_TURN && turn_cnt == 2'd2) begin
                    do_q <= START_BIT;
                    if (cmd == CMD_WR) begin
                        shreg    <= {START_BIT, ACK_OK, err, {N_DW{1'b0}}};
                        resp_cnt <= 6'd2;
                    end else begin
                        shreg    <= {START_BIT, err, rdata,
                                     sdp_parity(1'b0, sdp_vec_t'(rdata))};
                        resp_cnt <= 6'(N_DW + 2);
                    end
                end else begin
                    do_q <= 1'b1;
                    if (turn_cnt != 2'd2) turn_cnt <= turn_cnt + 2'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/sdp_slave.md
Name: sdp_slave

Overview:
- Target-side endpoint of the serial debug port (SDP).
- Decodes host write/read frames arriving on the bidirectional SDP data line.
- Issues one memory-bus access per frame and serialises the acknowledge, status and read data back to the host.
- Sits between the SDP pins and the on-chip debug bus master port; runs entirely in the system clock domain and oversamples sdp_ck.

Parameters:
- N_AW, 32, address width (bits in frame).
- N_DW, 32, data width.
- N_DM, 4, write-strobe width.
- BUS_TO, 1024, clk cycles to wait for bus response; 0 disables timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- sdp_ck  in  1  host serial clock; asynchronous; requires f_clk >= 8*f_sdp_ck
- sdp_di  in  1  serial data from pad
- sdp_do  out  1  serial data to pad
- sdp_oe  out  1  1 = slave drives pad
- bus_req_vld  out  1  bus request valid
- bus_req_rdy  in  1  bus request ready
- bus_req_we  out  1  1 = write
- bus_req_addr  out  N_AW  address
- bus_req_wdata  out  N_DW  write data
- bus_req_wstrb  out  N_DM  byte strobes
- bus_rsp_vld  in  1  response valid (single cycle)
- bus_rsp_rdata  in  N_DW  read data
- bus_rsp_err  in  1  bus error

Behaviour:
- Reset: sdp_oe=0, sdp_do=1, bus_req_vld=0, bus_req_* = 0, FSM=IDLE. Reset mid-frame aborts without a bus access; a bus handshake already completed is not undone.
- Input path: 2-flop synchronisers on sdp_ck and sdp_di. Rising/falling edges are detected on the synchronised sdp_ck.
- Sampling and driving:
  - Host bits are sampled on the synchronised sck falling edge.
  - Slave bits are changed on the synchronised sck rising edge.
- Host frame, MSB first, one bit per sck period:
  - start=0
  - cmd (1 = write, 0 = read)
  - addr[N_AW]
  - write only: wstrb[N_DM], then wdata[N_DW]
  - parity
  - stop=1
- Parity:
  - Write: parity = 1 ^ XOR(addr, wdata); strobes are excluded.
  - Read: parity = XOR(addr).
- FSM states: IDLE, CMD, ADDR, STRB, DATA, PAR, STOP, TURN, BUS_REQ, BUS_RSP, RESP, TAIL.
  - A 6-bit bit counter is loaded on entry to ADDR/STRB/DATA.
  - IDLE -> CMD when a sampled bit is 0; line high keeps IDLE.
- Stop bit sampled 0 = framing error: no bus access, no response; return to IDLE once a 1 is sampled.
- After a valid stop: TURN lasts two sck rising edges (host releases the line).
  - sdp_oe=1 and sdp_do=1 from the first of those edges.
  - The bus access runs concurrently.
- Bus access:
  - Skipped if parity is bad.
  - bus_req_vld is held with stable fields until bus_req_rdy.
  - Then the block waits for bus_rsp_vld.
  - A timeout counter counts from request acceptance; expiry is treated as an error.
- RESP starts at the first sck rise after both TURN and the bus access are done.
  - Write response: start=0, ack=0, status (0 ok; 1 on parity error, bus_rsp_err or timeout).
  - Read response: start=0, ack (0 ok; 1 on parity error, bus_rsp_err or timeout), rdata[N_DW] MSB first (all zero when ack=1), parity=XOR(rdata as sent).
- TAIL: drive 1 for one sck period, then sdp_oe=0 -> IDLE.
- Edges on sdp_ck while sdp_oe=1 do not sample input.
- bus_rsp_vld outside BUS_RSP is ignored.

Decomposition:
- sdp_pkg holds:
  - the state enum
  - the command encodings (CMD_WR=1, CMD_RD=0)
  - constants START_BIT=0, STOP_BIT=1, ACK_OK=0
  - the function sdp_parity(cnt_init, vec)
- One sub-module, sdp_sync_edge: 2-flop sync plus rise/fall pulse generation, instanced for sck and di.

Test Plan:
- Write addr 0x0000_0010, data 0x0000_0003, parity 0 -> one bus write with wstrb 0xF; response bits 0,0,0; line released afterwards.
- Read addr 0x1000_0004 (parity 0), bus returns 0x1234_5678 -> response 0,0, then 0x12345678, then parity 1.
- Write with flipped parity -> no bus_req_vld; response status=1.
- Read with bus_rsp_err=1 -> ack=1, data 0x00000000, parity 0.
- Stop bit 0 -> no bus access, sdp_oe stays 0; the next good frame completes normally.
- rst_n low during ADDR bits, and a read with bus_req_rdy low for 50 cycles.
  - Reset case: outputs return to reset values.
  - Stall case: request fields stay stable until accepted.
  - BUS_TO=16 with no response -> ack=1.
